// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: first bit on dout one cycle after accept, 1 bit/cycle.
// Backpressure: en=0 freezes the shift; a new word is taken only when idle or on the final consumed bit.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             en,
    output logic             dout,
    output logic             dout_valid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        dout_valid = 1'b0;
        dout       = 1'b0;
        last       = 1'b0;

        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    sh_d    = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                dout_valid = 1'b1;
                dout       = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];
                last       = (cnt_q == CNT_LAST);
                load_ready = last && en;
                if (en) begin
                    if (!last) begin
                        if (MSB_FIRST != 0) begin
                            sh_d = {sh_q[WIDTH-2:0], 1'b0};
                        end else begin
                            sh_d = {1'b0, sh_q[WIDTH-1:1]};
                        end
                        cnt_d = cnt_q + 1'b1;
                    end else if (load_valid) begin
                        // Reload on the final bit so consecutive words stream without a gap.
                        sh_d  = din;
                        cnt_d = '0;
                    end else begin
                        sh_d    = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance share all inputs.
module tb_piso_serializer;

    logic       c;
    logic       rst_n;
    logic [7:0] din;
    logic       load_valid;
    logic       en;

    logic load_ready_m, dout_m, dout_valid_m, last_m;
    logic load_ready_l, dout_l, dout_valid_l, last_l;

    int n_cmp;
    int n_err;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .c          (c),
        .rst_n      (rst_n),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready_m),
        .en         (en),
        .dout       (dout_m),
        .dout_valid (dout_valid_m),
        .last       (last_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .c          (c),
        .rst_n      (rst_n),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready_l),
        .en         (en),
        .dout       (dout_l),
        .dout_valid (dout_valid_l),
        .last       (last_l)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b0; din = 8'hFF; load_valid = 1'b1; en = 1'b1;
        #2;
        n_cmp++;
        if ({dout_m, dout_valid_m, last_m, load_ready_m} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_outputs got %b exp 0001", {dout_m, dout_valid_m, last_m, load_ready_m});
        end
        @(posedge c); @(posedge c); #1;
        n_cmp++;
        if (dout_valid_m !== 1'b0 || dout_valid_l !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_accept got %b%b exp 00", dout_valid_m, dout_valid_l);
        end
        load_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge c); #1;
        n_cmp++;
        if (dout_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle got %b exp 0", dout_valid_m);
        end
    endtask

    task automatic test_single;
        logic [7:0] w;
        w = 8'hA5;
        @(posedge c); #1; din = w; load_valid = 1'b1; en = 1'b1;
        @(posedge c); #1; load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge c);
            n_cmp++;
            if ({dout_m, dout_valid_m, last_m, load_ready_m} !== {w[7-i], 1'b1, (i == 7), (i == 7)}) begin
                n_err++;
                $display("FAIL single_bit%0d got dout/vld/last/rdy=%b exp %b", i,
                         {dout_m, dout_valid_m, last_m, load_ready_m}, {w[7-i], 1'b1, (i == 7), (i == 7)});
            end
        end
        @(negedge c);
        n_cmp++;
        if (dout_valid_m !== 1'b0 || load_ready_m !== 1'b1) begin
            n_err++;
            $display("FAIL single_cycle9 got vld=%b rdy=%b exp vld=0 rdy=1", dout_valid_m, load_ready_m);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] w;
        w = 16'hA53C;
        @(posedge c); #1; din = 8'hA5; load_valid = 1'b1; en = 1'b1;
        @(posedge c); #1; din = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            @(negedge c);
            n_cmp++;
            if (dout_m !== w[15-i] || dout_valid_m !== 1'b1 || last_m !== (i == 7 || i == 15)) begin
                n_err++;
                $display("FAIL b2b_bit%0d got dout=%b vld=%b last=%b exp dout=%b vld=1 last=%b", i,
                         dout_m, dout_valid_m, last_m, w[15-i], (i == 7 || i == 15));
            end
            if (i == 7) begin
                n_cmp++;
                if (load_ready_m !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_second_accept_ready got %b exp 1", load_ready_m);
                end
                @(posedge c); #1; load_valid = 1'b0;
            end
        end
        @(negedge c);
        n_cmp++;
        if (dout_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end got vld=%b exp 0", dout_valid_m);
        end
    endtask

    task automatic test_stall;
        logic [7:0] w;
        int b;
        w = 8'hA5;
        @(posedge c); #1; din = w; load_valid = 1'b1; en = 1'b1;
        @(posedge c); #1; load_valid = 1'b0;
        for (int t = 0; t < 11; t++) begin
            if (t > 0) begin
                @(posedge c); #1;
            end
            en = !(t >= 2 && t <= 4);
            b  = (t < 2) ? t : ((t < 5) ? 2 : t - 3);
            @(negedge c);
            n_cmp++;
            if (dout_m !== w[7-b] || dout_valid_m !== 1'b1 || last_m !== (b == 7)
                || load_ready_m !== (b == 7 && en)) begin
                n_err++;
                $display("FAIL stall_cycle%0d got dout=%b vld=%b last=%b rdy=%b exp dout=%b vld=1 last=%b rdy=%b",
                         t, dout_m, dout_valid_m, last_m, load_ready_m, w[7-b], (b == 7), (b == 7 && en));
            end
        end
        en = 1'b1;
        @(negedge c);
        n_cmp++;
        if (dout_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL stall_end got vld=%b exp 0", dout_valid_m);
        end
    endtask

    task automatic test_lsb;
        logic [15:0] words;
        logic [7:0]  w;
        words = 16'hA501;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? words[15:8] : words[7:0];
            @(posedge c); #1; din = w; load_valid = 1'b1; en = 1'b1;
            @(posedge c); #1; load_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge c);
                n_cmp++;
                if (dout_l !== w[i] || dout_valid_l !== 1'b1 || last_l !== (i == 7)
                    || load_ready_l !== (i == 7)) begin
                    n_err++;
                    $display("FAIL lsb_w%0d_bit%0d got dout=%b vld=%b last=%b rdy=%b exp dout=%b vld=1 last=%b rdy=%b",
                             k, i, dout_l, dout_valid_l, last_l, load_ready_l, w[i], (i == 7), (i == 7));
                end
            end
            @(negedge c);
            n_cmp++;
            if (dout_valid_l !== 1'b0) begin
                n_err++;
                $display("FAIL lsb_w%0d_end got vld=%b exp 0", k, dout_valid_l);
            end
        end
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] w;
        @(posedge c); #1; din = 8'hFF; load_valid = 1'b1; en = 1'b1;
        @(posedge c); #1; load_valid = 1'b0;
        repeat (4) @(posedge c);
        #2; rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dout_m, dout_valid_m, last_m, load_ready_m} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_mid_async got dout/vld/last/rdy=%b exp 0001",
                     {dout_m, dout_valid_m, last_m, load_ready_m});
        end
        w = 8'h80;
        din = w; load_valid = 1'b1;
        @(posedge c); #1;
        n_cmp++;
        if (dout_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_held_accept got vld=%b exp 0", dout_valid_m);
        end
        rst_n = 1'b1;
        @(posedge c); #1; load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge c);
            n_cmp++;
            if (dout_m !== w[7-i] || dout_valid_m !== 1'b1 || last_m !== (i == 7)) begin
                n_err++;
                $display("FAIL rst_mid_after_bit%0d got dout=%b vld=%b last=%b exp dout=%b vld=1 last=%b",
                         i, dout_m, dout_valid_m, last_m, w[7-i], (i == 7));
            end
        end
        @(negedge c);
        n_cmp++;
        if (dout_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_end got vld=%b exp 0", dout_valid_m);
        end
    endtask

    task automatic test_ignored_load;
        logic [7:0] w;
        w = 8'hA5;
        @(posedge c); #1; din = w; load_valid = 1'b1; en = 1'b1;
        @(posedge c); #1; load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge c); #1;
            end
            if (i >= 1 && i <= 5) begin
                din        = 8'h5A ^ 8'(i);
                load_valid = i[0];
            end else begin
                load_valid = 1'b0;
            end
            @(negedge c);
            n_cmp++;
            if (dout_m !== w[7-i] || dout_valid_m !== 1'b1 || last_m !== (i == 7)) begin
                n_err++;
                $display("FAIL ignored_bit%0d got dout=%b vld=%b last=%b exp dout=%b vld=1 last=%b",
                         i, dout_m, dout_valid_m, last_m, w[7-i], (i == 7));
            end
        end
        repeat (2) begin
            @(negedge c);
            n_cmp++;
            if (dout_valid_m !== 1'b0) begin
                n_err++;
                $display("FAIL ignored_extra_word got vld=%b exp 0", dout_valid_m);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_lsb();
        test_reset_mid_word();
        test_ignored_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per consumed cycle. The serial side is flow-controlled by a sink enable. It is the transmit end for our serial-in flip-flop shift chains: its serial output feeds a chain's `din`, and `c` is shared.

## Interface
- `WIDTH`, default 8: word width in bits; legal values are WIDTH ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 out first; 0 shifts bit 0 out first.
- `c`  input  1  clock; every flop is rising-edge triggered.
- `rst_n`  input  1  reset, asynchronous and active-low. One clock only.
- `din`  input  WIDTH  parallel word; sampled only on an accept edge.
- `load_valid`  input  1  producer has a word on `din`.
- `load_ready`  output  1  block can accept a word this cycle.
- `en`  input  1  serial sink enable. It acts as the sink's ready.
- `dout`  output  1  current serial bit.
- `dout_valid`  output  1  `dout` holds a valid bit.
- `last`  output  1  `dout` holds the final bit of the word.

## Operation
- State machine with two states: IDLE and SHIFT. Registers are the state, `sh[WIDTH-1:0]` and `cnt[$clog2(WIDTH)-1:0]`.
- An accept happens on a rising edge where `load_valid && load_ready`.
- A consume happens on a rising edge where `dout_valid && en`.
- IDLE:
  - `load_ready`=1, `dout_valid`=0, `last`=0, `dout`=0.
  - On accept: `sh`<=`din`, `cnt`<=0, state goes to SHIFT.
- SHIFT:
  - `dout_valid`=1.
  - `dout` = `sh[WIDTH-1]` when MSB_FIRST=1, otherwise `sh[0]`.
  - `last` = (`cnt`==WIDTH-1).
- Consume with `last`=0: shift `sh` toward the output end (fill with 0) and increment `cnt`.
- Consume with `last`=1, two cases:
  - `load_valid`=1: accept the new word in the same edge (`sh`<=`din`, `cnt`<=0, stay in SHIFT). There is no gap cycle between words.
  - `load_valid`=0: go to IDLE and clear `sh` to 0.
- `load_ready` = IDLE || (SHIFT && `last` && `en`). It is combinational from the state, `cnt` and `en`.
- `load_valid` outside `load_ready` is ignored. `din` changes while shifting have no effect.
- `en`=0 in SHIFT is a stall: `sh`, `cnt`, `dout`, `dout_valid` and `last` all hold.
- `dout`, `dout_valid` and `last` are decoded only from registers. They never depend combinationally on `din`, `load_valid` or `en`.
- Reset (`rst_n`=0) takes effect immediately, including mid-word:
  - state=IDLE, `sh`=0, `cnt`=0.
  - `dout`=0, `dout_valid`=0, `last`=0.
  - `load_ready` reads 1, but no accept is registered while `rst_n`=0.
  - The partially sent word is discarded. Nothing resumes after release.

## Timing
- Accept at edge k: `dout_valid`=1 and the first bit is on `dout` after edge k. That bit is consumed at edge k+1 if `en`=1.
- A word with `en` held at 1 occupies WIDTH cycles. `last` is high in the WIDTH-th cycle.
- Each `en`=0 cycle during SHIFT adds exactly one cycle.
- Back-to-back words give a continuous stream of `dout_valid`=1. Throughput is 1 bit per cycle.
- Idle-to-first-bit latency is 1 cycle from the accept edge.
- After the final consume with no new load, `dout_valid`=0 in the next cycle.
- First accept after reset release can happen at the first rising edge with `rst_n`=1.

## Test plan
- **Single word, MSB first:** WIDTH=8, MSB_FIRST=1, `en`=1, load 0xA5.
  - `dout` = 1,0,1,0,0,1,0,1 over 8 cycles.
  - `last` high only on the 8th bit. `load_ready`=0 for bits 1–7.
  - `dout_valid`=0 in cycle 9.
- **Back-to-back words:** 0xA5, then 0x3C presented with `load_valid` held high.
  - 16 consecutive valid bits: 10100101 00111100.
  - Second accept coincides with the first word's `last`. No bubble.
- **Stall:** load 0xA5, drive `en`=0 for 3 cycles after the 2nd bit is consumed.
  - `dout` holds 1 (bit 3) during the stall. `cnt`/`last` frozen.
  - Word completes in 11 cycles with the same bit sequence.
- **LSB first:** MSB_FIRST=0, load 0xA5. `dout` = 1,0,1,0,0,1,0,1 (0xA5 is bit-palindromic).
  - Then load 0x01: `dout` = 1,0,0,0,0,0,0,0.
- **Reset mid-word:** load 0xFF, assert `rst_n`=0 asynchronously after 4 bits.
  - Outputs go to 0 immediately, before the next edge.
  - After release, load 0x80: first `dout`=1 followed by seven 0s. No leftover 1s.
- **Ignored load:** change `din` and pulse `load_valid` during bits 2–6 of 0xA5.
  - Stream stays 0xA5. No extra word is sent.
